// File: rtl/mdu_param.sv
// mdu_param: parametrised multiply/divide unit holding the HI/LO registers.
// Long ops (mult/div/madd/msub class) latch their operands at issue and occupy
// a fixed number of busy cycles. The result is computed from the latched
// operands and the issue-time {hi,lo}. It commits on the last busy edge unless
// clr cancels the op first.
//
// state  | meaning
// S_IDLE | nothing in flight; mthi/mtlo write through, start may issue a long op
// S_RUN  | long op in flight; cnt_q counts down, commit happens when it is zero
module mdu_param #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             clr,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mdu_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  localparam int W2      = 2 * WIDTH;
  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  // Counter holds LAT-1 at most, so clog2(MAX_LAT) bits are enough.
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             op_is_long;
  logic             op_is_div;
  logic             issue;
  logic             tc;

  logic             mul_signed;
  logic [W2-1:0]    a_ext;
  logic [W2-1:0]    b_ext;
  logic [W2-1:0]    prod;
  logic [W2-1:0]    hilo;
  logic             div_signed;
  logic             div_zero;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             q_is_div;
  logic [W2-1:0]    res;
  logic             res_ok;

  // Classify the incoming op and decide whether this edge issues a long op
  always_comb begin
    op_is_long = 1'b0;
    op_is_div  = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: op_is_long = 1'b1;
      OP_DIV, OP_DIVU: begin
        op_is_long = 1'b1;
        op_is_div  = 1'b1;
      end
      default: ;
    endcase
    issue = (state_q == S_IDLE) && start && op_is_long && !clr;
    tc    = (cnt_q == '0);
  end

  // State register and datapath flops; synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state logic: a cancel or the terminal count ends the run
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (issue) state_d = S_RUN;
      S_RUN:  if (clr || tc) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Arithmetic on the latched operands; only used on the commit edge
  always_comb begin
    mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    a_ext      = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext      = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod       = a_ext * b_ext;
    hilo       = {hi_q, lo_q};

    // Signed divide works on magnitudes. MIN/-1 falls out naturally: the
    // magnitude 2^(W-1) negates back to MIN and the remainder is zero.
    div_signed = (op_q == OP_DIV);
    div_zero   = (b_q == '0);
    neg_a      = div_signed & a_q[WIDTH-1];
    neg_b      = div_signed & b_q[WIDTH-1];
    mag_a      = neg_a ? -a_q : a_q;
    mag_b      = neg_b ? -b_q : b_q;
    divisor    = div_zero ? ONE : mag_b;
    uq         = mag_a / divisor;
    ur         = mag_a % divisor;
    quo        = (neg_a ^ neg_b) ? -uq : uq;
    rem        = neg_a ? -ur : ur;

    q_is_div   = (op_q == OP_DIV) || (op_q == OP_DIVU);
    res_ok     = !(q_is_div && div_zero);
    case (op_q)
      OP_MULT, OP_MULTU: res = prod;
      OP_MADD, OP_MADDU: res = hilo + prod;
      OP_MSUB, OP_MSUBU: res = hilo - prod;
      OP_DIV, OP_DIVU:   res = {rem, quo};
      default:           res = hilo;
    endcase
  end

  // Datapath next values: mthi/mtlo and issue latch in IDLE, count/commit in RUN
  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    case (state_q)
      S_IDLE: begin
        // clr only cancels long ops, so moves to HI/LO still land
        if (op == OP_MTHI) hi_d = src_a;
        if (op == OP_MTLO) lo_d = src_a;
        if (issue) begin
          op_d  = op;
          a_d   = src_a;
          b_d   = src_b;
          cnt_d = op_is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      S_RUN: begin
        if (clr) begin
          cnt_d = '0;
        end else if (tc) begin
          if (res_ok) begin
            hi_d = res[W2-1:WIDTH];
            lo_d = res[WIDTH-1:0];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs: busy follows the RUN state, mdu_out is a pure decode of op
  always_comb begin
    busy = (state_q == S_RUN);
    hi   = hi_q;
    lo   = lo_q;
    case (op)
      OP_MFHI: mdu_out = hi_q;
      OP_MFLO: mdu_out = lo_q;
      default: mdu_out = '0;
    endcase
  end

endmodule

// File: doc/mdu_param.md
Name: mdu_param

Overview:
Parametrised multiply/divide unit for the E stage of the 5-stage MIPS pipeline. It is the next generation of the fixed-latency MDU:
- configurable operand width and latencies
- adds madd/maddu/msub/msubu accumulate ops
- defines a precise cancel rule and divide-by-zero rule
It holds the HI/LO architectural registers and drives busy to the hazard unit, which stalls MDU-class instructions in D while start or busy is high.

Parameters:
WIDTH, 32, operand and HI/LO width
MULT_LAT, 5, busy cycles for mult/multu/madd/maddu/msub/msubu (>=1)
DIV_LAT, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low; reset==0 at a rising edge resets the block
start  input  1  E-stage instruction is a long MDU op (mult/div/madd class)
op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9 madd, 10 maddu, 11 msub, 12 msubu; 13-15 treated as none
src_a  input  WIDTH  rs operand (forwarded)
src_b  input  WIDTH  rt operand (forwarded)
clr  input  1  flush: cancel the in-flight long op
busy  output  1  long op in progress
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
mdu_out  output  WIDTH  mfhi returns hi; mflo returns lo; all other ops return 0 (combinational from op)

Behaviour:
- Reset (reset==0 at an edge): hi=0, lo=0, busy=0, counter=0, latched operands=0. This overrides any in-flight op.
- FSM states: IDLE and RUN.
- IDLE -> RUN: start=1, op is a long op (1-4, 9-12), clr=0.
  - src_a, src_b and op are latched.
  - counter loads MULT_LAT-1 or DIV_LAT-1.
  - busy=1 from the next cycle.
- RUN: counter decrements each edge.
- RUN -> IDLE at the edge where counter==0 and clr=0:
  - result commits to {hi,lo}.
  - busy falls at the same edge.
- Latency: start sampled at edge T. busy=1 during cycles T+1..T+LAT. New hi/lo are visible from T+LAT+1.
- Result rules, WIDTH-bit operands:
  - mult: signed 2*WIDTH product. hi=upper half, lo=lower half.
  - multu: same as mult, unsigned.
  - madd/maddu: {hi,lo} = {hi,lo} + product (signed/unsigned), modulo 2^(2*WIDTH). Uses hi/lo at issue; they cannot change during RUN.
  - msub/msubu: {hi,lo} = {hi,lo} - product, same rules as madd/maddu.
  - div: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - div, MIN/-1: lo=MIN, hi=0.
  - divu: unsigned quotient/remainder.
  - Divide by zero: busy runs the full DIV_LAT, then hi/lo are left unchanged.
- mthi/mtlo:
  - When busy=0, write src_a into hi/lo at the next edge; start is not required.
  - When busy=1, they are ignored (the hazard unit guarantees none are issued).
- start while busy=1: ignored; the in-flight op is unaffected.
- start with a non-long op: ignored.
- clr=1:
  - In RUN: at the next edge busy=0 and the FSM returns to IDLE. hi/lo keep their pre-issue values; no partial commit.
  - Same edge as the commit edge: clr wins and there is no commit.
  - Simultaneous clr and start in IDLE: start is dropped.
  - clr in IDLE with no start: no effect.
  - clr does not block mthi/mtlo in the same cycle.
- Implementation freedom: arithmetic may be computed at issue or at commit, provided the visible timing above holds exactly.

Test Plan:
1. mthi/mtlo then mult: mthi 0, mtlo 0, then start op=1, a=3, b=32'hFFFFFFFE -> busy high exactly 5 cycles; next cycle hi=32'hFFFFFFFF, lo=32'hFFFFFFFA; mflo gives mdu_out=32'hFFFFFFFA.
2. Unsigned and signed divide:
   - divu a=7, b=2 -> busy 10 cycles, then lo=3, hi=1.
   - div a=32'hFFFFFFF9, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
   - div a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
3. Divide by zero: hi=5, lo=6, div a=9, b=0 -> busy 10 cycles; hi=5, lo=6 unchanged.
4. Accumulate:
   - mthi 0, mtlo 10, madd a=4, b=5 -> hi=0, lo=30.
   - hi=0, lo=0, msubu a=1, b=1 -> hi=lo=32'hFFFFFFFF.
5. Cancel: hi=1, lo=2, mult issued, clr=1 in 3rd busy cycle -> busy 0 next cycle, hi=1, lo=2.
   - Repeat with clr on the commit edge (5th busy cycle) -> no commit.
   - Second start during busy -> ignored.
6. Reset mid-op and parameters:
   - reset=0 during a div -> next cycle busy=0, hi=lo=0.
   - Re-instantiate with WIDTH=16, MULT_LAT=1, DIV_LAT=3: multu 16'hFFFF*16'hFFFF -> busy 1 cycle, hi=16'hFFFE, lo=16'h0001.
   - Same instance: divu 100/7 -> busy 3 cycles, lo=14, hi=2.
